// File: rtl/openmips_min_sopc.sv
// Instruction ROM: combinational word-addressed lookup, returns NOP while fetch is disabled.
// Latency: zero cycles (pure combinational read).
// Backpressure: none; a new address can be presented every cycle.
module inst_rom #(
    parameter int ROM_DEPTH = 1024
) (
    input  logic        ce,
    input  logic [31:0] addr,
    output logic [31:0] inst
);
    localparam int AW = $clog2(ROM_DEPTH);

    logic [31:0] inst_mem [0:ROM_DEPTH-1];
    logic        unused_addr;

    // Byte-offset and out-of-range address bits do not select a word.
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
    assign inst        = ce ? inst_mem[addr[AW+1:2]] : 32'h0;
endmodule

// General purpose register file: 32 x 32, two read ports, one write port, r0 hardwired to zero.
// Latency: write lands on the clock edge; reads are combinational and see a same-cycle write.
// Backpressure: none.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);
    logic [31:0] regs [0:31];

    // Only r0 is cleared by reset; the other registers keep their contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs[0] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // Read port 1 with write-first bypass so WB needs no separate forward path.
    always_comb begin
        if (raddr1 == 5'd0)                rdata1 = '0;
        else if (we && waddr == raddr1)    rdata1 = wdata;
        else                               rdata1 = regs[raddr1];
    end

    // Read port 2, same policy as port 1.
    always_comb begin
        if (raddr2 == 5'd0)                rdata2 = '0;
        else if (we && waddr == raddr2)    rdata2 = wdata;
        else                               rdata2 = regs[raddr2];
    end
endmodule

// HI/LO special registers written together by DIV.
// Latency: update visible immediately after the write edge.
// Backpressure: none.
module hilo_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] wdata_hi,
    input  logic [31:0] wdata_lo,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    // Hold HI/LO, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (we) begin
            hi <= wdata_hi;
            lo <= wdata_lo;
        end
    end
endmodule

// Five-stage in-order MIPS32 subset core, branches resolved in ID with one delay slot.
// Latency: an instruction fetched at edge N writes back at edge N+4; full forwarding, no bubbles.
// Backpressure: none; the pipeline never stalls and nothing is squashed.
module openmips (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rom_data,
    output logic [31:0] rom_addr,
    output logic        rom_ce
);
    typedef enum logic [2:0] {OP_NOP, OP_OR, OP_SLL, OP_LINK, OP_DIV, OP_MFHI, OP_MFLO} aluop_t;

    logic [31:0] pc, id_pc, id_inst, pc_delay, link_addr, br_target;
    logic        ce, br_flag;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rf_rdata1, rf_rdata2, rs_val, rt_val;
    aluop_t      dec_op, ex_op;
    logic [31:0] dec_reg1, dec_reg2, ex_reg1, ex_reg2;
    logic [4:0]  dec_wd, ex_wd, mem_wd, wb_wd;
    logic        dec_wreg, ex_wreg, mem_wreg, wb_wreg;
    logic [31:0] ex_wdata, mem_wdata, wb_wdata;
    logic        ex_whilo, mem_whilo, wb_whilo;
    logic [31:0] ex_hi, ex_lo, mem_hi, mem_lo, wb_hi, wb_lo;
    logic [31:0] hilo_hi, hilo_lo, hi_cur, lo_cur, dvs;

    assign rom_addr  = pc;
    assign rom_ce    = ce;
    assign rs        = id_inst[25:21];
    assign rt        = id_inst[20:16];
    assign rd        = id_inst[15:11];
    assign pc_delay  = id_pc + 32'd4;
    assign link_addr = id_pc + 32'd8;

    // Fetch: first edge after reset only enables the ROM, then step or redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            ce <= 1'b0;
        end else if (!ce) begin
            ce <= 1'b1;
        end else begin
            pc <= br_flag ? br_target : pc + 32'd4;
        end
    end

    // IF/ID latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc   <= '0;
            id_inst <= '0;
        end else begin
            id_pc   <= pc;
            id_inst <= rom_data;
        end
    end

    regfile regfile1 (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_wreg),
        .waddr  (wb_wd),
        .wdata  (wb_wdata),
        .raddr1 (rs),
        .rdata1 (rf_rdata1),
        .raddr2 (rt),
        .rdata2 (rf_rdata2)
    );

    // Operand bypass: youngest producer (EX) wins over MEM; WB is handled by the regfile.
    always_comb begin
        rs_val = rf_rdata1;
        rt_val = rf_rdata2;
        if (rs != 5'd0 && ex_wreg && ex_wd == rs)         rs_val = ex_wdata;
        else if (rs != 5'd0 && mem_wreg && mem_wd == rs)  rs_val = mem_wdata;
        if (rt != 5'd0 && ex_wreg && ex_wd == rt)         rt_val = ex_wdata;
        else if (rt != 5'd0 && mem_wreg && mem_wd == rt)  rt_val = mem_wdata;
    end

    // Decode and branch resolution; unknown encodings fall through as NOP.
    always_comb begin
        dec_op    = OP_NOP;
        dec_reg1  = rs_val;
        dec_reg2  = rt_val;
        dec_wd    = rd;
        dec_wreg  = 1'b0;
        br_flag   = 1'b0;
        br_target = rs_val;
        case (id_inst[31:26])
            6'h0d: begin
                dec_op   = OP_OR;
                dec_wreg = 1'b1;
                dec_wd   = rt;
                dec_reg2 = {16'h0, id_inst[15:0]};
            end
            6'h02, 6'h03: begin
                br_flag   = 1'b1;
                br_target = (pc_delay & 32'hF000_0000) | {4'h0, id_inst[25:0], 2'b00};
                if (id_inst[26]) begin
                    dec_op   = OP_LINK;
                    dec_wreg = 1'b1;
                    dec_wd   = 5'd31;
                    dec_reg1 = link_addr;
                end
            end
            6'h00: begin
                case (id_inst[5:0])
                    6'h25: begin
                        dec_op   = OP_OR;
                        dec_wreg = 1'b1;
                    end
                    6'h00: begin
                        dec_op   = OP_SLL;
                        dec_wreg = 1'b1;
                        dec_reg1 = {27'h0, id_inst[10:6]};
                    end
                    6'h08: br_flag = 1'b1;
                    6'h09: begin
                        br_flag  = 1'b1;
                        dec_op   = OP_LINK;
                        dec_wreg = 1'b1;
                        dec_reg1 = link_addr;
                    end
                    6'h1a: dec_op = OP_DIV;
                    6'h10: begin
                        dec_op   = OP_MFHI;
                        dec_wreg = 1'b1;
                    end
                    6'h12: begin
                        dec_op   = OP_MFLO;
                        dec_wreg = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // ID/EX latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_op   <= OP_NOP;
            ex_reg1 <= '0;
            ex_reg2 <= '0;
            ex_wd   <= '0;
            ex_wreg <= 1'b0;
        end else begin
            ex_op   <= dec_op;
            ex_reg1 <= dec_reg1;
            ex_reg2 <= dec_reg2;
            ex_wd   <= dec_wd;
            ex_wreg <= dec_wreg;
        end
    end

    // Execute: HI/LO seen by MFHI/MFLO include DIVs still in MEM or WB.
    always_comb begin
        hi_cur = hilo_hi;
        lo_cur = hilo_lo;
        if (mem_whilo) begin
            hi_cur = mem_hi;
            lo_cur = mem_lo;
        end else if (wb_whilo) begin
            hi_cur = wb_hi;
            lo_cur = wb_lo;
        end
        case (ex_op)
            OP_OR:   ex_wdata = ex_reg1 | ex_reg2;
            OP_SLL:  ex_wdata = ex_reg2 << ex_reg1[4:0];
            OP_LINK: ex_wdata = ex_reg1;
            OP_MFHI: ex_wdata = hi_cur;
            OP_MFLO: ex_wdata = lo_cur;
            default: ex_wdata = '0;
        endcase
    end

    // Single-cycle signed divide; a zero divisor suppresses the HI/LO write.
    always_comb begin
        ex_whilo = (ex_op == OP_DIV) && (ex_reg2 != 32'h0);
        dvs      = (ex_reg2 == 32'h0) ? 32'd1 : ex_reg2;
        if (ex_reg1 == 32'h8000_0000 && ex_reg2 == 32'hFFFF_FFFF) begin
            ex_lo = 32'h8000_0000;
            ex_hi = 32'h0;
        end else begin
            ex_lo = $signed(ex_reg1) / $signed(dvs);
            ex_hi = $signed(ex_reg1) % $signed(dvs);
        end
    end

    // EX/MEM latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
        end else begin
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_whilo <= ex_whilo;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
        end
    end

    // MEM/WB latch; there is no data memory so MEM just passes results along.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wd    <= '0;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
            wb_whilo <= 1'b0;
            wb_hi    <= '0;
            wb_lo    <= '0;
        end else begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
            wb_whilo <= mem_whilo;
            wb_hi    <= mem_hi;
            wb_lo    <= mem_lo;
        end
    end

    hilo_reg hilo_reg0 (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_whilo),
        .wdata_hi (wb_hi),
        .wdata_lo (wb_lo),
        .hi       (hilo_hi),
        .lo       (hilo_lo)
    );
endmodule

// Minimal SoC: openmips core fetching from a preloadable instruction ROM, no data memory.
// Latency: first instruction writes back on the sixth edge after reset release.
// Backpressure: none.
module openmips_min_sopc #(
    parameter int ROM_DEPTH = 1024
) (
    input  logic clk,
    input  logic rst
);
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ce;

    openmips openmips0 (
        .clk      (clk),
        .rst      (rst),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .rom_ce   (rom_ce)
    );

    inst_rom #(.ROM_DEPTH(ROM_DEPTH)) inst_rom0 (
        .ce   (rom_ce),
        .addr (rom_addr),
        .inst (rom_data)
    );
endmodule

// File: tb/tb_openmips_min_sopc.sv
module tb_openmips_min_sopc;
    logic        clk;
    logic        rst;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          edge_no;
    logic [31:0] rom_img [0:1023];
    logic [31:0] m_reg   [0:31];
    logic        m_known [0:31];
    logic [31:0] m_hi, m_lo, m_pc, m_npc;
    int          chk_regs [8] = '{1, 2, 3, 4, 5, 6, 7, 31};

    openmips_min_sopc #(.ROM_DEPTH(1024)) dut (.clk(clk), .rst(rst));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_ori(input int rt, input int rs, input logic [15:0] imm);
        return {6'h0d, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] i_r(input int rs, input int rt, input int rd, input int sa,
                                        input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sa), fn};
    endfunction

    function automatic logic [31:0] i_j(input logic [5:0] op, input logic [31:0] tgt);
        return {op, tgt[27:2]};
    endfunction

    task automatic m_write(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) begin
            m_reg[r]   = v;
            m_known[r] = 1'b1;
        end
    endtask

    // Instruction-set level model: executes one instruction with delay-slot semantics.
    task automatic model_step();
        logic [31:0] ins, a, b, nxt;
        logic [4:0]  rs, rt, rd;
        ins = rom_img[m_pc[11:2]];
        rs  = ins[25:21];
        rt  = ins[20:16];
        rd  = ins[15:11];
        a   = m_reg[rs];
        b   = m_reg[rt];
        nxt = m_npc + 32'd4;
        case (ins[31:26])
            6'h0d: m_write(rt, a | {16'h0, ins[15:0]});
            6'h02: nxt = ((m_pc + 32'd4) & 32'hF000_0000) | {4'h0, ins[25:0], 2'b00};
            6'h03: begin
                nxt = ((m_pc + 32'd4) & 32'hF000_0000) | {4'h0, ins[25:0], 2'b00};
                m_write(5'd31, m_pc + 32'd8);
            end
            6'h00: begin
                case (ins[5:0])
                    6'h25: m_write(rd, a | b);
                    6'h00: m_write(rd, b << ins[10:6]);
                    6'h08: nxt = a;
                    6'h09: begin
                        nxt = a;
                        m_write(rd, m_pc + 32'd8);
                    end
                    6'h1a: begin
                        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                            m_lo = a;
                            m_hi = 32'h0;
                        end else if (b != 32'h0) begin
                            m_lo = $signed(a) / $signed(b);
                            m_hi = $signed(a) % $signed(b);
                        end
                    end
                    6'h10: m_write(rd, m_hi);
                    6'h12: m_write(rd, m_lo);
                    default: ;
                endcase
            end
            default: ;
        endcase
        m_pc  = m_npc;
        m_npc = nxt;
    endtask

    task automatic compare_state();
        foreach (chk_regs[i]) begin
            if (m_known[chk_regs[i]])
                check($sformatf("r%0d@e%0d", chk_regs[i], edge_no),
                      dut.openmips0.regfile1.regs[chk_regs[i]], m_reg[chk_regs[i]]);
        end
        check($sformatf("hi@e%0d", edge_no), dut.openmips0.hilo_reg0.hi, m_hi);
        check($sformatf("lo@e%0d", edge_no), dut.openmips0.hilo_reg0.lo, m_lo);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom_img[i] = 32'h0;
    endtask

    task automatic begin_run();
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) dut.inst_rom0.inst_mem[i] = rom_img[i];
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_pc    = 32'h0;
        m_npc   = 32'h4;
        m_hi    = 32'h0;
        m_lo    = 32'h0;
        edge_no = 0;
    endtask

    task automatic run_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_no++;
            if (edge_no >= 6) model_step();
            compare_state();
        end
    endtask

    task automatic build_prog1();
        clear_rom();
        rom_img[0]  = i_ori(1, 0, 16'h0001);
        rom_img[1]  = i_j(6'h02, 32'h20);
        rom_img[2]  = i_ori(1, 0, 16'h0002);
        rom_img[3]  = i_ori(1, 0, 16'h1111);
        rom_img[8]  = i_ori(1, 0, 16'h0003);
        rom_img[9]  = i_j(6'h03, 32'h40);
        rom_img[10] = i_r(31, 1, 0, 0, 6'h1a);
        rom_img[11] = i_ori(1, 0, 16'h0005);
        rom_img[12] = i_ori(1, 0, 16'h0006);
        rom_img[13] = i_j(6'h02, 32'h60);
        rom_img[16] = i_r(31, 0, 2, 0, 6'h09);
        rom_img[17] = i_r(2, 0, 1, 0, 6'h25);
        rom_img[18] = i_ori(1, 0, 16'h0009);
        rom_img[19] = i_ori(1, 0, 16'h000A);
        rom_img[20] = i_j(6'h02, 32'h50);
        rom_img[24] = i_ori(1, 0, 16'h0007);
        rom_img[25] = i_r(2, 0, 0, 0, 6'h08);
        rom_img[26] = i_ori(1, 0, 16'h0008);
    endtask

    task automatic build_prog2();
        clear_rom();
        rom_img[0]  = i_ori(3, 0, 16'hFFFF);
        rom_img[1]  = i_r(0, 3, 3, 16, 6'h00);
        rom_img[2]  = i_ori(3, 3, 16'hFFF9);
        rom_img[3]  = i_ori(4, 0, 16'h0002);
        rom_img[4]  = i_ori(5, 0, 16'h0000);
        rom_img[5]  = i_r(3, 4, 0, 0, 6'h1a);
        rom_img[6]  = i_r(0, 0, 6, 0, 6'h12);
        rom_img[7]  = i_r(0, 0, 7, 0, 6'h10);
        rom_img[8]  = i_r(3, 5, 0, 0, 6'h1a);
        rom_img[9]  = i_r(0, 0, 1, 0, 6'h10);
        rom_img[10] = i_j(6'h02, 32'h28);
    endtask

    task automatic build_random();
        logic prev_br;
        int   k;
        clear_rom();
        for (int r = 1; r <= 7; r++)
            rom_img[r-1] = i_ori(r, 0, ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
        prev_br = 1'b0;
        for (int i = 7; i < 37; i++) begin
            if (!prev_br && i < 33 && $urandom_range(0, 9) == 0) begin
                rom_img[i] = i_j(($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03,
                                 32'(4 * (i + $urandom_range(2, 3))));
                prev_br = 1'b1;
            end else begin
                prev_br = 1'b0;
                k = $urandom_range(0, 5);
                case (k)
                    0: rom_img[i] = i_ori($urandom_range(1, 7), $urandom_range(0, 7), 16'($urandom));
                    1: rom_img[i] = i_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 7), 0, 6'h25);
                    2: rom_img[i] = i_r(0, $urandom_range(0, 7), $urandom_range(1, 7), $urandom_range(0, 31), 6'h00);
                    3: rom_img[i] = i_r($urandom_range(0, 7), $urandom_range(0, 7), 0, 0, 6'h1a);
                    4: rom_img[i] = i_r(0, 0, $urandom_range(1, 7), 0, 6'h10);
                    default: rom_img[i] = i_r(0, 0, $urandom_range(1, 7), 0, 6'h12);
                endcase
            end
        end
        rom_img[37] = i_j(6'h02, 32'(37 * 4));
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            m_reg[i]   = 32'h0;
            m_known[i] = 1'b0;
        end
        repeat (10) @(posedge clk);
        #1;
        check("rst_hi", dut.openmips0.hilo_reg0.hi, 32'h0);
        check("rst_lo", dut.openmips0.hilo_reg0.lo, 32'h0);
        check("rst_pc", dut.openmips0.pc, 32'h0);
        check("rst_ce", 32'(dut.openmips0.ce), 32'h0);

        // Jump / link / delay-slot walk.
        build_prog1();
        begin_run();
        run_edges(6);
        check("p1_r1_e6", dut.openmips0.regfile1.regs[1], 32'h1);
        run_edges(39);
        check("p1_r1_end", dut.openmips0.regfile1.regs[1], 32'h0000_000A);
        check("p1_r2_end", dut.openmips0.regfile1.regs[2], 32'h0000_0048);
        check("p1_r31_end", dut.openmips0.regfile1.regs[31], 32'h0000_002C);
        check("p1_hi_end", dut.openmips0.hilo_reg0.hi, 32'h0000_0002);
        check("p1_lo_end", dut.openmips0.hilo_reg0.lo, 32'h0000_000E);

        // Negative divide, HI/LO forwarding, divide by zero.
        build_prog2();
        begin_run();
        run_edges(30);
        check("p2_r3", dut.openmips0.regfile1.regs[3], 32'hFFFF_FFF9);
        check("p2_lo", dut.openmips0.hilo_reg0.lo, 32'hFFFF_FFFD);
        check("p2_hi", dut.openmips0.hilo_reg0.hi, 32'hFFFF_FFFF);
        check("p2_mflo_fwd", dut.openmips0.regfile1.regs[6], 32'hFFFF_FFFD);
        check("p2_mfhi_fwd", dut.openmips0.regfile1.regs[7], 32'hFFFF_FFFF);
        check("p2_div0_hi", dut.openmips0.regfile1.regs[1], 32'hFFFF_FFFF);

        // Reset in the middle of a program.
        build_prog1();
        begin_run();
        run_edges(14);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_hi", dut.openmips0.hilo_reg0.hi, 32'h0);
        check("mid_rst_lo", dut.openmips0.hilo_reg0.lo, 32'h0);
        check("mid_rst_pc", dut.openmips0.pc, 32'h0);
        begin_run();
        run_edges(45);
        check("mid_rst_r1_end", dut.openmips0.regfile1.regs[1], 32'h0000_000A);

        // Random straight-line code with dense dependencies and forward jumps.
        for (int t = 0; t < 6; t++) begin
            build_random();
            begin_run();
            run_edges(55);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
